// File: rtl/apb_slave_mem.sv
// apb_slave_mem: APB responder with a small byte-wide register memory.
// A transfer captured in its setup phase runs a programmable number of wait
// states, then completes with PREADY. During the access phase the block
// compares the bus against the captured address/direction/data and flags any
// change. It also flags out-of-range addresses. Errors are reported on PSLVERR.
// Errored writes are dropped, errored reads return zero, and every errored or
// aborted transfer is counted.
//
// Ports:
//   PCLK, PRESETn      clock, asynchronous active-low reset
//   PSEL, PENABLE      APB select / access-phase strobe
//   PWRITE, PADDR      direction and byte address (low bits from the bridge)
//   PWDATA, PRDATA     write / read data
//   PREADY, PSLVERR    transfer complete / error response (valid with PREADY)
//   err_count          saturating count of errored completions and aborts
module apb_slave_mem #(
    parameter int ADDR_WIDTH  = 8,
    parameter int DATA_WIDTH  = 8,
    parameter int DEPTH       = 64,
    parameter int WAIT_STATES = 2
) (
    input  logic                  PCLK,
    input  logic                  PRESETn,
    input  logic                  PSEL,
    input  logic                  PENABLE,
    input  logic                  PWRITE,
    input  logic [ADDR_WIDTH-1:0] PADDR,
    input  logic [DATA_WIDTH-1:0] PWDATA,
    output logic [DATA_WIDTH-1:0] PRDATA,
    output logic                  PREADY,
    output logic                  PSLVERR,
    output logic [7:0]            err_count
);

    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_WIDTH:0] DEPTH_LIM = (ADDR_WIDTH + 1)'(DEPTH);
    localparam logic [3:0] WAIT_INIT = 4'(WAIT_STATES);

    typedef enum logic {
        IDLE   = 1'b0,
        ACCESS = 1'b1
    } state_t;

    state_t state, next_state;

    logic [3:0]            wait_cnt;
    logic                  sticky_err;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic                  write_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic [DATA_WIDTH-1:0] rdata_q;
    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic setup;
    logic ready;
    logic mismatch;
    logic complete;
    logic abort;
    logic err_now;
    logic in_range;

    // Range check done one bit wider so DEPTH == 2^ADDR_WIDTH is representable.
    assign in_range = ({1'b0, PADDR} < DEPTH_LIM);

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        setup      = 1'b0;
        ready      = 1'b0;
        mismatch   = 1'b0;
        complete   = 1'b0;
        abort      = 1'b0;
        case (state)
            IDLE: begin
                // PENABLE high without a preceding setup is ignored here.
                if (PSEL && !PENABLE) begin
                    setup      = 1'b1;
                    next_state = ACCESS;
                end
            end
            ACCESS: begin
                // Ready depends only on registered state, never on PENABLE.
                ready    = (wait_cnt == 4'd0);
                mismatch = (PADDR != addr_q) || (PWRITE != write_q) ||
                           (write_q && (PWDATA != wdata_q));
                if (PSEL && PENABLE) begin
                    if (ready) begin
                        complete   = 1'b1;
                        next_state = IDLE;
                    end
                end else begin
                    // A setup cycle arriving here is deliberately not captured.
                    abort      = 1'b1;
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    assign err_now = sticky_err | mismatch;
    assign PREADY  = ready;
    assign PSLVERR = ready & err_now;
    // An errored read returns zero even when the violation is seen only in
    // the completion cycle itself.
    assign PRDATA  = err_now ? '0 : rdata_q;

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            wait_cnt   <= 4'd0;
            sticky_err <= 1'b0;
            addr_q     <= '0;
            write_q    <= 1'b0;
            wdata_q    <= '0;
            rdata_q    <= '0;
            err_count  <= 8'd0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (setup) begin
                addr_q     <= PADDR;
                write_q    <= PWRITE;
                wdata_q    <= PWDATA;
                wait_cnt   <= WAIT_INIT;
                // Clearing the flag and the range error share this edge.
                sticky_err <= !in_range;
                rdata_q    <= (!PWRITE && in_range) ? mem[PADDR[IDX_W-1:0]] : '0;
            end else if (state == ACCESS) begin
                if (complete || abort) begin
                    rdata_q <= '0;
                end else begin
                    wait_cnt   <= wait_cnt - 4'd1;
                    sticky_err <= err_now;
                end
            end

            // No error implies the latched address is in range.
            if (complete && write_q && !err_now) begin
                mem[addr_q[IDX_W-1:0]] <= wdata_q;
            end

            if (((complete && err_now) || abort) && (err_count != 8'hFF)) begin
                err_count <= err_count + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_apb_slave_mem.sv
// Testbench for apb_slave_mem. Two instances share the APB bus: one with two
// wait states and one with zero wait states. A select signal steers PSEL to
// one of them. Expected responses are queued at setup and compared at
// completion.
module tb_apb_slave_mem;

    logic       pclk = 1'b0;
    logic       presetn;
    logic       psel, penable, pwrite;
    logic [7:0] paddr, pwdata;
    logic       sel_ws0;

    logic [7:0] prdata2, prdata0, errc2, errc0;
    logic       pready2, pready0, pslverr2, pslverr0;
    logic [7:0] prdata;
    logic       pready, pslverr;

    int vectors = 0;
    int miscompares = 0;

    typedef struct {
        logic [7:0] rdata;
        logic       slverr;
        int         lat;
    } exp_t;

    exp_t       sb[$];
    logic [7:0] mmem [2][64];
    int         merr [2];
    int         wsv  [2] = '{2, 0};

    always #5 pclk = ~pclk;

    apb_slave_mem #(.ADDR_WIDTH(8), .DATA_WIDTH(8), .DEPTH(64), .WAIT_STATES(2)) dut2 (
        .PCLK(pclk), .PRESETn(presetn), .PSEL(psel & ~sel_ws0), .PENABLE(penable),
        .PWRITE(pwrite), .PADDR(paddr), .PWDATA(pwdata), .PRDATA(prdata2),
        .PREADY(pready2), .PSLVERR(pslverr2), .err_count(errc2)
    );

    apb_slave_mem #(.ADDR_WIDTH(8), .DATA_WIDTH(8), .DEPTH(64), .WAIT_STATES(0)) dut0 (
        .PCLK(pclk), .PRESETn(presetn), .PSEL(psel & sel_ws0), .PENABLE(penable),
        .PWRITE(pwrite), .PADDR(paddr), .PWDATA(pwdata), .PRDATA(prdata0),
        .PREADY(pready0), .PSLVERR(pslverr0), .err_count(errc0)
    );

    assign prdata  = sel_ws0 ? prdata0  : prdata2;
    assign pready  = sel_ws0 ? pready0  : pready2;
    assign pslverr = sel_ws0 ? pslverr0 : pslverr2;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            merr[k] = 0;
            for (int j = 0; j < 64; j++) mmem[k][j] = 8'h00;
        end
        sb.delete();
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge pclk); #1;
            psel    = 1'b0;
            penable = 1'b0;
        end
    endtask

    // One APB transfer. mut_cyc >= 1 replaces PWDATA with mut_d from that
    // access cycle onward.
    task automatic xfer(input logic ws0, input logic wr, input logic [7:0] a,
                        input logic [7:0] d, input int mut_cyc, input logic [7:0] mut_d,
                        input string tag);
        exp_t e;
        int   idx;
        int   cyc;
        logic err;
        logic done;
        idx = ws0 ? 1 : 0;
        err = (a >= 8'd64) || (wr && (mut_cyc > 0) && (mut_d != d));
        e.rdata  = (!wr && !err) ? mmem[idx][a[5:0]] : 8'h00;
        e.slverr = err;
        e.lat    = 1 + wsv[idx];
        if (wr && !err) mmem[idx][a[5:0]] = d;
        if (err && merr[idx] < 255) merr[idx]++;

        @(posedge pclk); #1;
        sel_ws0 = ws0;
        psel    = 1'b1;
        penable = 1'b0;
        pwrite  = wr;
        paddr   = a;
        pwdata  = d;
        sb.push_back(e);

        cyc  = 0;
        done = 1'b0;
        while (!done && cyc < 20) begin
            @(posedge pclk); #1;
            cyc++;
            penable = 1'b1;
            if (cyc == mut_cyc) pwdata = mut_d;
            @(negedge pclk);
            if (pready) done = 1'b1;
        end

        if (sb.size() == 0) begin
            chk({tag, "_sb_empty"}, 32'd0, 32'd1);
        end else begin
            e = sb.pop_front();
            if (!done) begin
                chk({tag, "_timeout"}, 32'(pready), 32'd1);
            end else begin
                chk({tag, "_latency"}, 32'(cyc), 32'(e.lat));
                chk({tag, "_pslverr"}, 32'(pslverr), 32'(e.slverr));
                if (!wr) chk({tag, "_prdata"}, 32'(prdata), 32'(e.rdata));
            end
        end
    endtask

    task automatic chk_errc(input logic ws0, input string tag);
        if (ws0) chk(tag, 32'(errc0), 32'(merr[1]));
        else     chk(tag, 32'(errc2), 32'(merr[0]));
    endtask

    initial begin
        presetn = 1'b0;
        psel    = 1'b0;
        penable = 1'b0;
        pwrite  = 1'b0;
        paddr   = 8'h00;
        pwdata  = 8'h00;
        sel_ws0 = 1'b0;
        model_reset();

        #12;
        chk("rst_pready",  32'(pready2),  32'd0);
        chk("rst_pslverr", 32'(pslverr2), 32'd0);
        chk("rst_prdata",  32'(prdata2),  32'd0);
        chk("rst_errc2",   32'(errc2),    32'd0);
        chk("rst_errc0",   32'(errc0),    32'd0);
        @(negedge pclk);
        presetn = 1'b1;

        // PENABLE high without setup must not start a transfer.
        @(posedge pclk); #1;
        psel = 1'b1; penable = 1'b1; pwrite = 1'b1; paddr = 8'h09; pwdata = 8'h99;
        @(negedge pclk);
        chk("idle_pen_ready0", 32'(pready2), 32'd0);
        @(posedge pclk); #1;
        @(negedge pclk);
        chk("idle_pen_ready1", 32'(pready2), 32'd0);
        idle(2);

        // Write then read with two wait states.
        xfer(1'b0, 1'b1, 8'h10, 8'hA5, 0, 8'h00, "ws2_wr10");
        xfer(1'b0, 1'b0, 8'h10, 8'h00, 0, 8'h00, "ws2_rd10");
        xfer(1'b0, 1'b0, 8'h09, 8'h00, 0, 8'h00, "ws2_rd09");
        idle(1);

        // Zero-wait back-to-back writes and reads.
        xfer(1'b1, 1'b1, 8'h01, 8'h11, 0, 8'h00, "ws0_wr1");
        xfer(1'b1, 1'b1, 8'h02, 8'h22, 0, 8'h00, "ws0_wr2");
        xfer(1'b1, 1'b1, 8'h03, 8'h33, 0, 8'h00, "ws0_wr3");
        xfer(1'b1, 1'b0, 8'h01, 8'h00, 0, 8'h00, "ws0_rd1");
        xfer(1'b1, 1'b0, 8'h02, 8'h00, 0, 8'h00, "ws0_rd2");
        xfer(1'b1, 1'b0, 8'h03, 8'h00, 0, 8'h00, "ws0_rd3");
        idle(1);
        chk_errc(1'b1, "ws0_errc");

        // Out-of-range write then read.
        xfer(1'b0, 1'b1, 8'h40, 8'hFF, 0, 8'h00, "oor_wr40");
        idle(1);
        chk_errc(1'b0, "oor_errc1");
        xfer(1'b0, 1'b0, 8'h40, 8'h00, 0, 8'h00, "oor_rd40");
        idle(1);
        chk_errc(1'b0, "oor_errc2");

        // PWDATA changes during the first wait cycle.
        xfer(1'b0, 1'b1, 8'h05, 8'h12, 1, 8'h34, "stab_wr05");
        idle(1);
        chk_errc(1'b0, "stab_errc");
        xfer(1'b0, 1'b0, 8'h05, 8'h00, 0, 8'h00, "stab_rd05");
        idle(1);

        // Abort: PSEL dropped in the first wait cycle of a write.
        @(posedge pclk); #1;
        sel_ws0 = 1'b0; psel = 1'b1; penable = 1'b0; pwrite = 1'b1;
        paddr = 8'h07; pwdata = 8'h5C;
        @(posedge pclk); #1;
        psel = 1'b0;
        @(negedge pclk);
        chk("abort_pready", 32'(pready2), 32'd0);
        if (merr[0] < 255) merr[0]++;
        idle(1);
        chk_errc(1'b0, "abort_errc");
        xfer(1'b0, 1'b0, 8'h07, 8'h00, 0, 8'h00, "abort_rd07");
        xfer(1'b0, 1'b1, 8'h07, 8'h77, 0, 8'h00, "post_wr07");
        xfer(1'b0, 1'b0, 8'h07, 8'h00, 0, 8'h00, "post_rd07");
        idle(1);
        chk_errc(1'b0, "post_errc");

        // Reset asserted in the middle of a read's wait phase.
        @(posedge pclk); #1;
        sel_ws0 = 1'b0; psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = 8'h10;
        @(posedge pclk); #1;
        penable = 1'b1;
        @(negedge pclk);
        chk("midrst_prdata_pre", 32'(prdata2), 32'hA5);
        #2;
        presetn = 1'b0;
        #1;
        chk("midrst_pready",  32'(pready2),  32'd0);
        chk("midrst_pslverr", 32'(pslverr2), 32'd0);
        chk("midrst_prdata",  32'(prdata2),  32'd0);
        chk("midrst_errc",    32'(errc2),    32'd0);
        psel    = 1'b0;
        penable = 1'b0;
        model_reset();
        @(negedge pclk);
        presetn = 1'b1;
        xfer(1'b0, 1'b0, 8'h10, 8'h00, 0, 8'h00, "midrst_rd10");
        idle(2);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/apb_slave_mem.md
# apb_slave_mem

APB responder holding a small byte-wide register memory. One instance sits behind each PSEL line driven by the two-slave APB bridge; the bridge routes on PADDR[8], and this block sees only the low address bits. It adds programmable wait states, checks protocol stability during the access phase, and reports errors on PSLVERR.

## Interface
Parameters:
- ADDR_WIDTH, 8: width of PADDR seen by the slave.
- DATA_WIDTH, 8: width of PWDATA/PRDATA.
- DEPTH, 64: implemented locations (0..DEPTH-1); DEPTH ≤ 2^ADDR_WIDTH.
- WAIT_STATES, 2: wait cycles inserted before PREADY (0..15).

Ports:
- PCLK, input, 1: the single clock; all state changes on its rising edge.
- PRESETn, input, 1: reset, asynchronous, active-low.
- PSEL, input, 1: slave select from the bridge.
- PENABLE, input, 1: access-phase indicator.
- PWRITE, input, 1: 1 = write, 0 = read.
- PADDR, input, ADDR_WIDTH: byte address.
- PWDATA, input, DATA_WIDTH: write data.
- PRDATA, output, DATA_WIDTH: read data.
- PREADY, output, 1: transfer complete.
- PSLVERR, output, 1: error response, valid only while PREADY=1.
- err_count, output, 8: saturating count of error completions.

## Operation
- States: IDLE and ACCESS.
- IDLE -> ACCESS when PSEL=1 and PENABLE=0 (setup phase). On that edge the block:
  - latches PADDR, PWRITE and PWDATA;
  - loads wait counter = WAIT_STATES;
  - clears the sticky error flag;
  - if it is a read and the address is in range, loads the PRDATA register with mem[PADDR]; otherwise loads 0.
- PENABLE=1 while in IDLE is ignored and produces no response.
- ACCESS, PSEL=1 and PENABLE=1:
  - counter > 0: decrement; PREADY=0.
  - counter = 0: PREADY=1; the transfer completes on this edge, and the next state is IDLE.
- Error sources, each of which sets the sticky flag:
  - latched address ≥ DEPTH (set at setup);
  - PADDR, PWRITE, or (for writes) PWDATA differs from the latched value during any ACCESS cycle.
- PSLVERR = PREADY & (sticky flag | same-cycle mismatch).
- Write commit: mem[latched addr] ← latched PWDATA at the completion edge, only if PWRITE was latched and there is no error.
- Errored reads return PRDATA=0.
- err_count increments on each completion with PSLVERR=1 and saturates at 255.
- Abort: if PSEL=0 or PENABLE=0 in ACCESS before completion, go to IDLE.
  - No write; no PREADY; err_count increments.
  - If the abort cycle is itself a setup (PSEL=1, PENABLE=0), that cycle is **not** captured. The master must re-issue it.
- Back-to-back transfers: completion returns to IDLE, and the master's next setup cycle is captured normally. There is no dead cycle beyond the APB-mandated setup phase.

## Timing
- Reset (asynchronous assert, released synchronously to PCLK by the system):
  - state=IDLE, counter=0, sticky flag=0;
  - PRDATA=0, PREADY=0, PSLVERR=0, err_count=0;
  - all DEPTH memory locations = 0.
- PREADY and PSLVERR are decoded from registered state and counter plus the same-cycle compare. There is no combinational path from PENABLE to PREADY.
- Latency:
  - setup at cycle 0; PREADY high in cycle 1+WAIT_STATES;
  - WAIT_STATES=0 gives a zero-wait transfer (PREADY in cycle 1).
- PRDATA is valid from cycle 1 until completion and returns to 0 on the edge after completion.
- Reset asserted mid-ACCESS: immediate return to IDLE with all outputs at reset values, and any pending write is dropped.
- Read of a location written by the immediately preceding transfer returns the new data, because the write commits before the next setup edge.

## Test plan
- **Reset**: assert PRESETn=0 mid-ACCESS with WAIT_STATES=2 -> PREADY, PSLVERR and PRDATA go to 0 asynchronously; err_count=0.
- **Write/read, WAIT_STATES=2**: write 0xA5 to addr 0x10, then read 0x10.
  - PREADY is high exactly in cycle 3 of each transfer.
  - PRDATA=0xA5; PSLVERR=0.
- **Zero-wait back-to-back (WAIT_STATES=0)**: write 0x11/0x22/0x33 to addresses 1/2/3 on consecutive transfers, then read all three.
  - PREADY in cycle 1 of every transfer; data reads back exactly.
- **Out of range**: write 0xFF to addr 0x40 (DEPTH=64) -> PSLVERR=1 with PREADY; err_count=1; the following read of 0x40 returns PRDATA=0 with PSLVERR=1.
- **Stability violation**: write to 0x05, changing PWDATA from 0x12 to 0x34 during the wait cycle -> PSLVERR=1; mem[5] is unchanged (a read returns 0).
- **Abort**: drop PSEL in the first wait cycle of a write to 0x07 -> no PREADY, no write; err_count increments; the next normal transfer completes cleanly.
